fetch: RTL

- Instruction fetch stage directly upstream of decode.
- Reads one 32-bit instruction from the 8-bit-wide instruction memory as four little-endian byte reads, then presents it on `inst` with a one-cycle `ready` pulse.
- `ready` drives decode's `en`. Decode consumes `inst` on the following clocks.
- Owns the program counter. Advances it by 4 per completed fetch. Accepts a redirect (jump/branch target) while idle.

---
 rtl/fetch.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: assembles one little-endian instruction from four
// byte-wide memory reads, then pulses ready towards decode and advances the PC.
module fetch #(
  parameter int unsigned            M_WIDTH    = 8,
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0]  RESET_INST = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [M_WIDTH-1:0]    mem_data,
  input  logic                  mem_ack,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  ready
);

  localparam int unsigned BYTES    = INST_WIDTH / M_WIDTH;
  localparam int unsigned IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned SHADOW_W = INST_WIDTH - M_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [SHADOW_W-1:0]   shadow_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; redirect wins over a fetch request in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!pc_load && en) state_d = FETCH;
      FETCH:   if (mem_ack && (idx_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request decode
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (state_q == FETCH) begin
      mem_req  = 1'b1;
      mem_addr = pc + ADDR_WIDTH'(idx_q);
    end
  end

  // Datapath: byte assembly into the shadow buffer keeps inst stable mid-fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inst     <= RESET_INST;
      idx_q    <= '0;
      shadow_q <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= 1'b0;
      busy  <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (pc_load) pc    <= pc_next;
          else if (en) idx_q <= '0;
        end
        FETCH: begin
          if (mem_ack) begin
            if (idx_q == LAST_IDX) begin
              inst  <= {mem_data, shadow_q};
              ready <= 1'b1;
            end else begin
              shadow_q[int'(idx_q)*M_WIDTH +: M_WIDTH] <= mem_data;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE:    pc <= pc + ADDR_WIDTH'(BYTES);
        default: ;
      endcase
    end
  end

endmodule
